// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the iterative multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of RUN cycles needed to retire all multiplier bits.
    function automatic int unsigned mult_lat(input int unsigned width, input int unsigned step);
        return width / step;
    endfunction

    // Width of the iteration counter, wide enough to hold LAT.
    function automatic int unsigned mult_cnt_w(input int unsigned width, input int unsigned step);
        return $clog2(mult_lat(width, step) + 1);
    endfunction

endpackage

// File: rtl/mult_pp_step.sv
// Combinational partial product: mcand times one STEP-bit multiplier digit.
// With MULT_ITER_SIGNED_EN defined, the digit flagged by `last` carries
// negative weight on its top bit (two's-complement multiplier).
module mult_pp_step
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 2
) (
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [STEP-1:0]    digit,
    input  logic               last,
    output logic [2*WIDTH-1:0] pp
);

`ifndef MULT_ITER_SIGNED_EN
    logic unused_last;
    assign unused_last = last;
`endif

    // Unsigned digit product; in signed mode a negative final digit is
    // corrected by subtracting mcand * 2^STEP (modulo 2^(2*WIDTH)).
    always_comb begin
        pp = mcand * (2*WIDTH)'(digit);
`ifdef MULT_ITER_SIGNED_EN
        if (last && digit[STEP-1]) begin
            pp = pp - (mcand << STEP);
        end
`endif
    end

endmodule

// File: rtl/mult_iter.sv
// Iterative multiplier retiring STEP multiplier bits per cycle.
// Optional feature: MULT_ITER_SIGNED_EN selects two's-complement operands.
module mult_iter
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               go,
    input  logic [WIDTH-1:0]   left,
    input  logic [WIDTH-1:0]   right,
    output logic [2*WIDTH-1:0] out,
    output logic               done,
    output logic               busy
);

    localparam int unsigned LAT = mult_lat(WIDTH, STEP);
    localparam int unsigned CW  = mult_cnt_w(WIDTH, STEP);

    if (WIDTH < 2 || (STEP != 1 && STEP != 2 && STEP != 4 && STEP != 8) ||
        (WIDTH % STEP) != 0) begin : g_param_err
        $error("mult_iter: illegal WIDTH/STEP combination");
    end

    state_t             state;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] pp;
    logic               last;
    logic [2*WIDTH-1:0] acc_next;

    // mcand is pre-shifted left by STEP every cycle, so the product already
    // carries the count*STEP weight without a variable shifter.
    assign last     = (cnt == CW'(LAT - 1));
    assign acc_next = acc + pp;

    mult_pp_step #(
        .WIDTH(WIDTH),
        .STEP (STEP)
    ) u_pp (
        .mcand(mcand),
        .digit(mplier[STEP-1:0]),
        .last (last),
        .pp   (pp)
    );

    // FSM with operand shift registers, accumulator and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            out    <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (go) begin
`ifdef MULT_ITER_SIGNED_EN
                        mcand <= {{WIDTH{left[WIDTH-1]}}, left};
`else
                        mcand <= {{WIDTH{1'b0}}, left};
`endif
                        mplier <= right;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << STEP;
                    mplier <= mplier >> STEP;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        out   <= acc_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_iter.sv
// Directed self-checking bench for mult_iter at WIDTH=8 with STEP=2, 1 and 8.
module tb_mult_iter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        go = 1'b0;
    logic [7:0]  left = '0;
    logic [7:0]  right = '0;

    logic [15:0] out2, out1, out8;
    logic        done2, done1, done8;
    logic        busy2, busy1, busy8;

    int n_checks = 0;
    int n_errors = 0;
    int t2, t1, t8, nbusy, ndone;

    always #5 clk = ~clk;

    mult_iter #(.WIDTH(8), .STEP(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .go(go), .left(left), .right(right),
        .out(out2), .done(done2), .busy(busy2)
    );
    mult_iter #(.WIDTH(8), .STEP(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .go(go), .left(left), .right(right),
        .out(out1), .done(done1), .busy(busy1)
    );
    mult_iter #(.WIDTH(8), .STEP(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .go(go), .left(left), .right(right),
        .out(out8), .done(done8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse go for one cycle (cycle 0), scramble operands afterwards, then
    // record the first done cycle of each DUT over a bounded window.
    task automatic op(input logic [7:0] l, input logic [7:0] r);
        @(negedge clk);
        go = 1'b1; left = l; right = r;
        @(posedge clk);
        #1;
        go = 1'b0; left = 8'hA5; right = 8'h5A;
        t2 = -1; t1 = -1; t8 = -1; nbusy = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy2) nbusy++;
            if (done2 && t2 < 0) t2 = k;
            if (done1 && t1 < 0) t1 = k;
            if (done8 && t8 < 0) t8 = k;
        end
    endtask

    initial begin
        #1;
        check("rst_out", 32'(out2), 32'h0);
        check("rst_done", 32'(done2), 32'h0);
        check("rst_busy", 32'(busy2), 32'h0);
        check("rst_out1", 32'(out1), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        op(8'd13, 8'd11);
        check("lat_s2", 32'(t2), 32'd5);
        check("lat_s1", 32'(t1), 32'd9);
        check("lat_s8", 32'(t8), 32'd2);
        check("busy_cycles", 32'(nbusy), 32'd4);
        check("out_13x11_s2", 32'(out2), 32'h008F);
        check("out_13x11_s1", 32'(out1), 32'h008F);
        check("out_13x11_s8", 32'(out8), 32'h008F);

        op(8'd255, 8'd255);
`ifdef MULT_ITER_SIGNED_EN
        check("out_ffxff_s2", 32'(out2), 32'h0001);
        check("out_ffxff_s1", 32'(out1), 32'h0001);
        check("out_ffxff_s8", 32'(out8), 32'h0001);
`else
        check("out_ffxff_s2", 32'(out2), 32'hFE01);
        check("out_ffxff_s1", 32'(out1), 32'hFE01);
        check("out_ffxff_s8", 32'(out8), 32'hFE01);
`endif
        check("lat_ff_s1", 32'(t1), 32'd9);
        check("lat_ff_s8", 32'(t8), 32'd2);

`ifdef MULT_ITER_SIGNED_EN
        op(8'hFD, 8'h05);
        check("sgn_m3x5_s2", 32'(out2), 32'hFFF1);
        check("sgn_m3x5_s1", 32'(out1), 32'hFFF1);
        check("sgn_m3x5_s8", 32'(out8), 32'hFFF1);
        op(8'h80, 8'h80);
        check("sgn_80x80_s2", 32'(out2), 32'h4000);
        check("sgn_80x80_s1", 32'(out1), 32'h4000);
        check("sgn_80x80_s8", 32'(out8), 32'h4000);
`endif

        // Back-to-back: second go held during the DONE cycle of the first.
        @(negedge clk);
        go = 1'b1; left = 8'd3; right = 8'd4;
        @(posedge clk);
        #1 go = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done2) begin
                ndone++;
                if (ndone == 1) begin
                    check("b2b_t1", 32'(k), 32'd5);
                    check("b2b_out1", 32'(out2), 32'd12);
                end else begin
                    check("b2b_t2", 32'(k), 32'd10);
                    check("b2b_out2", 32'(out2), 32'd42);
                end
            end
            if (k == 9) check("b2b_hold", 32'(out2), 32'd12);
            if (k == 5) begin
                go = 1'b1; left = 8'd7; right = 8'd6;
            end else if (k == 6) begin
                go = 1'b0;
            end
        end
        check("b2b_ndone", 32'(ndone), 32'd2);

        // go raised during RUN with different operands must be ignored.
        @(negedge clk);
        go = 1'b1; left = 8'd13; right = 8'd11;
        @(posedge clk);
        #1 go = 1'b0;
        ndone = 0; t2 = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done2) begin
                ndone++;
                if (t2 < 0) t2 = k;
            end
            if (k == 2) begin
                go = 1'b1; left = 8'd100; right = 8'd100;
            end else if (k == 3) begin
                go = 1'b0;
            end
            if (k == 8) check("run_go_busy", 32'(busy2), 32'h0);
        end
        check("run_go_t", 32'(t2), 32'd5);
        check("run_go_ndone", 32'(ndone), 32'd1);
        check("run_go_out", 32'(out2), 32'h008F);

        // Reset in the middle of an operation abandons it.
        @(negedge clk);
        go = 1'b1; left = 8'd13; right = 8'd11;
        @(posedge clk);
        #1 go = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_out", 32'(out2), 32'h0);
        check("midrst_busy", 32'(busy2), 32'h0);
        check("midrst_done", 32'(done2), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done2) ndone++;
        end
        check("midrst_nodone", 32'(ndone), 32'd0);

        op(8'd2, 8'd2);
        check("post_rst_t", 32'(t2), 32'd5);
        check("post_rst_out", 32'(out2), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
